// File: rtl/ram_scan_pkg.sv
// ram_scan_pkg: types shared by the RAM scanner block.
//   state_e : controller state (IDLE = normal operation, CLEAR = memory sweep)
package ram_scan_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_e;

endpackage : ram_scan_pkg

// File: rtl/tick_gen.sv
// tick_gen: scan-rate divider. While en is high it counts 0..SCAN_DIV-1 and
// raises tick for the single cycle spent at SCAN_DIV-1, then wraps to 0.
// While en is low the count is held at 0, so the first tick after en rises
// comes SCAN_DIV cycles later.
// Ports:
//   clock : rising-edge clock
//   reset : asynchronous active-high reset
//   en    : count enable
//   tick  : one-cycle strobe at the terminal count
module tick_gen #(
    parameter int SCAN_DIV = 50_000_000
) (
    input  logic clock,
    input  logic reset,
    input  logic en,
    output logic tick
);

    // SCAN_DIV = 1 still needs a 1-bit counter; it simply never leaves 0.
    localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(SCAN_DIV - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    assign tick = en && (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q;
        if (!en || tick) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule : tick_gen

// File: rtl/ram_scanner.sv
// ram_scanner: DEPTH x DATA_W memory with a registered display port that
// either follows a manual address or auto-scans through all words, plus a
// controller that sweeps the whole memory to zero on request.
//
// State table:
//   state | meaning
//   IDLE  | user writes accepted, waiting for clear_req
//   CLEAR | writing 0 to word clr_cnt each cycle, user writes dropped
//
// Ports:
//   clock, reset       : rising-edge clock, async active-high reset
//   wr_en/addr/data    : user write port (accepted only in IDLE)
//   mode               : 0 = display man_addr, 1 = display auto-scan address
//   man_addr           : manual display address
//   clear_req          : start a full-memory clear sweep
//   rd_addr, rd_data   : registered displayed address and its data
//   busy               : high while the clear sweep runs
//   wr_drop            : one-cycle pulse after a user write was rejected
module ram_scanner
    import ram_scan_pkg::*;
#(
    parameter int DATA_W   = 4,
    parameter int ADDR_W   = 5,
    parameter int SCAN_DIV = 50_000_000
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              mode,
    input  logic [ADDR_W-1:0] man_addr,
    input  logic              clear_req,
    output logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic              busy,
    output logic              wr_drop
);

    localparam int DEPTH = 2 ** ADDR_W;

    // No reset on the array so it can map onto block RAM.
    logic [DATA_W-1:0] mem [DEPTH];

    state_e            state_q;
    logic [ADDR_W-1:0] clr_cnt_q;
    logic              busy_q;
    logic              wr_drop_q;

    logic [ADDR_W-1:0] scan_addr_q;
    logic [ADDR_W-1:0] scan_addr_d;
    logic [ADDR_W-1:0] rd_addr_q;
    logic [DATA_W-1:0] rd_data_q;
    logic [DATA_W-1:0] rd_data_d;

    logic              scan_tick;
    logic [ADDR_W-1:0] sel_addr;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [DATA_W-1:0] mem_wdata;

    tick_gen #(
        .SCAN_DIV(SCAN_DIV)
    ) u_tick_gen (
        .clock(clock),
        .reset(reset),
        .en   (mode),
        .tick (scan_tick)
    );

    // Natural ADDR_W-bit overflow gives the DEPTH-1 -> 0 wrap.
    assign scan_addr_d = scan_tick ? scan_addr_q + 1'b1 : scan_addr_q;

    assign sel_addr = mode ? scan_addr_q : man_addr;

    // A single write port shared by the clear sweep and the user.
    assign mem_we    = (state_q == CLEAR) || (wr_en && (state_q == IDLE));
    assign mem_waddr = (state_q == CLEAR) ? clr_cnt_q : wr_addr;
    assign mem_wdata = (state_q == CLEAR) ? '0 : wr_data;

    // Write-first: a same-cycle write to the displayed word shows the new value.
    assign rd_data_d = (mem_we && (mem_waddr == sel_addr)) ? mem_wdata : mem[sel_addr];

    always_ff @(posedge clock) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            scan_addr_q <= '0;
            rd_addr_q   <= '0;
            rd_data_q   <= '0;
        end else begin
            scan_addr_q <= scan_addr_d;
            rd_addr_q   <= sel_addr;
            rd_data_q   <= rd_data_d;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            clr_cnt_q <= '0;
            busy_q    <= 1'b0;
            wr_drop_q <= 1'b0;
        end else begin
            wr_drop_q <= (state_q == CLEAR) && wr_en;
            case (state_q)
                IDLE: begin
                    if (clear_req) begin
                        state_q   <= CLEAR;
                        clr_cnt_q <= '0;
                        busy_q    <= 1'b1;
                    end
                end
                CLEAR: begin
                    if (clr_cnt_q == '1) begin
                        state_q   <= IDLE;
                        clr_cnt_q <= '0;
                        busy_q    <= 1'b0;
                    end else begin
                        clr_cnt_q <= clr_cnt_q + 1'b1;
                    end
                end
            endcase
        end
    end

    assign rd_addr = rd_addr_q;
    assign rd_data = rd_data_q;
    assign busy    = busy_q;
    assign wr_drop = wr_drop_q;

endmodule : ram_scanner

// File: tb/tb_ram_scanner.sv
// tb_ram_scanner: directed bench for ram_scanner with a behavioural model.
// A second instance with SCAN_DIV = 1 checks the every-cycle scan and wrap.
module tb_ram_scanner;

    localparam int DW    = 4;
    localparam int AW    = 5;
    localparam int DEPTH = 32;
    localparam int DIV   = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          wr_en = 1'b0;
    logic [AW-1:0] wr_addr = '0;
    logic [DW-1:0] wr_data = '0;
    logic          mode = 1'b0;
    logic [AW-1:0] man_addr = '0;
    logic          clear_req = 1'b0;
    logic [AW-1:0] rd_addr;
    logic [DW-1:0] rd_data;
    logic          busy;
    logic          wr_drop;

    logic          one1 = 1'b1;
    logic          zero1 = 1'b0;
    logic [AW-1:0] zero_a = '0;
    logic [DW-1:0] zero_d = '0;
    logic [AW-1:0] rd_addr1;
    logic [DW-1:0] rd_data1;
    logic          busy1;
    logic          wr_drop1;

    int total = 0;
    int bad   = 0;
    bit chk_on = 1'b0;

    always #5 clk = ~clk;

    ram_scanner #(.DATA_W(DW), .ADDR_W(AW), .SCAN_DIV(DIV)) dut (
        .clock(clk), .reset(rst), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .mode(mode), .man_addr(man_addr),
        .clear_req(clear_req), .rd_addr(rd_addr), .rd_data(rd_data),
        .busy(busy), .wr_drop(wr_drop)
    );

    ram_scanner #(.DATA_W(DW), .ADDR_W(AW), .SCAN_DIV(1)) dut1 (
        .clock(clk), .reset(rst), .wr_en(zero1), .wr_addr(zero_a),
        .wr_data(zero_d), .mode(one1), .man_addr(zero_a),
        .clear_req(zero1), .rd_addr(rd_addr1), .rd_data(rd_data1),
        .busy(busy1), .wr_drop(wr_drop1)
    );

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Model: memory contents, scan position as (completed steps of earlier
    // runs) + (cycles in current mode=1 run)/DIV, and remaining clear words.
    int m_mem [DEPTH];
    bit m_known [DEPTH];
    int scan_base = 0;
    int run_len = 0;
    int clear_left = 0;
    int e_addr = 0;
    int e_data = 0;
    bit e_data_valid = 1'b1;
    int e_busy = 0;
    int e_drop = 0;
    int edges1 = 0;

    always @(posedge clk) begin : model
        int  sel, cur, waddr, wdata;
        bit  we;
        if (rst) begin
            scan_base = 0; run_len = 0; clear_left = 0;
            e_addr = 0; e_data = 0; e_data_valid = 1'b1;
            e_busy = 0; e_drop = 0; edges1 = 0;
        end else begin
            cur = (scan_base + run_len / DIV) % DEPTH;
            sel = mode ? cur : int'(man_addr);
            we = 1'b0; waddr = 0; wdata = 0;
            if (clear_left > 0) begin
                we = 1'b1; waddr = DEPTH - clear_left; wdata = 0;
            end else if (wr_en) begin
                we = 1'b1; waddr = int'(wr_addr); wdata = int'(wr_data);
            end
            e_addr = sel;
            if (we && waddr == sel) begin
                e_data = wdata; e_data_valid = 1'b1;
            end else begin
                e_data = m_mem[sel]; e_data_valid = m_known[sel];
            end
            if (we) begin
                m_mem[waddr] = wdata; m_known[waddr] = 1'b1;
            end
            e_drop = (clear_left > 0 && wr_en) ? 1 : 0;
            if (clear_left > 0) clear_left--;
            else if (clear_req) clear_left = DEPTH;
            e_busy = (clear_left > 0) ? 1 : 0;
            if (mode) begin
                run_len++;
            end else begin
                scan_base += run_len / DIV;
                run_len = 0;
            end
            edges1++;
        end
    end

    always @(posedge clk) begin : compare
        #1;
        if (!rst && chk_on) begin
            chk("rd_addr", int'(rd_addr), e_addr);
            if (e_data_valid) chk("rd_data", int'(rd_data), e_data);
            chk("busy", int'(busy), e_busy);
            chk("wr_drop", int'(wr_drop), e_drop);
            if (edges1 > 0) chk("div1_rd_addr", int'(rd_addr1), (edges1 - 1) % DEPTH);
        end
    end

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int n;
        #1 rst = 1'b1;
        #1;
        chk("rst_rd_addr", int'(rd_addr), 0);
        chk("rst_rd_data", int'(rd_data), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_wr_drop", int'(wr_drop), 0);
        chk("rst_div1_addr", int'(rd_addr1), 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk_on = 1'b1;

        // Preload mem[k] = k mod 16 while displaying the word being written.
        for (int k = 0; k < DEPTH; k++) begin
            wr_en = 1'b1; wr_addr = AW'(k); wr_data = DW'(k % 16); man_addr = AW'(k);
            cyc();
        end
        chk("preload_bypass", int'(rd_data), 15);
        chk("div1_at_31", int'(rd_addr1), 31);

        wr_en = 1'b1; wr_addr = 5'd2; wr_data = 4'd8; man_addr = 5'd0;
        cyc();
        chk("div1_wrap_0", int'(rd_addr1), 0);
        wr_en = 1'b0; man_addr = 5'd2;
        cyc();
        chk("man_addr2", int'(rd_addr), 2);
        chk("man_data2", int'(rd_data), 8);

        wr_en = 1'b1; wr_addr = 5'd5; wr_data = 4'hA; man_addr = 5'd5;
        cyc();
        chk("bypass_5", int'(rd_data), 10);

        wr_addr = 5'd2; wr_data = 4'd2;
        cyc();
        wr_addr = 5'd5; wr_data = 4'd5;
        cyc();
        wr_en = 1'b0;

        // Auto-scan: one step per 4 cycles through all 32 words and back to 0.
        mode = 1'b1;
        for (int i = 1; i <= 129; i++) begin
            cyc();
            if (i == 4) chk("scan_hold0", int'(rd_addr), 0);
            if (i == 5) begin
                chk("scan_step1", int'(rd_addr), 1);
                chk("scan_data1", int'(rd_data), 1);
            end
            if (i == 128) begin
                chk("scan_31", int'(rd_addr), 31);
                chk("scan_data31", int'(rd_data), 15);
            end
        end
        chk("scan_wrap", int'(rd_addr), 0);
        chk("scan_wrap_data", int'(rd_data), 0);
        mode = 1'b0;
        repeat (3) cyc();

        // Clear sweep with a rejected write and an ignored second request.
        man_addr = 5'd3; clear_req = 1'b1;
        cyc();
        clear_req = 1'b0;
        n = 0;
        while (busy && n < 100) begin
            n++;
            wr_en = (n == 5); wr_addr = 5'd2; wr_data = 4'd9;
            clear_req = (n == 8);
            if (n == 6) chk("drop_pulse", int'(wr_drop), 1);
            cyc();
        end
        wr_en = 1'b0; clear_req = 1'b0;
        chk("busy_cycles", n, 32);
        for (int k = 0; k < DEPTH; k++) begin
            man_addr = AW'(k);
            cyc();
            chk("cleared_word", int'(rd_data), 0);
        end

        // Reset in the middle of a sweep.
        wr_en = 1'b1;
        wr_addr = 5'd20; wr_data = 4'hC; cyc();
        wr_addr = 5'd5;  wr_data = 4'd7; cyc();
        wr_addr = 5'd25; wr_data = 4'd9; cyc();
        wr_en = 1'b0; man_addr = 5'd20; clear_req = 1'b1;
        cyc();
        clear_req = 1'b0;
        repeat (10) cyc();
        chk("mid_clear_busy", int'(busy), 1);
        chk("mid_clear_data", int'(rd_data), 12);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("async_busy", int'(busy), 0);
        chk("async_rd_data", int'(rd_data), 0);
        chk("async_rd_addr", int'(rd_addr), 0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        man_addr = 5'd20;
        cyc();
        chk("kept_20", int'(rd_data), 12);
        man_addr = 5'd5;
        cyc();
        chk("cleared_5", int'(rd_data), 0);
        man_addr = 5'd25;
        cyc();
        chk("kept_25", int'(rd_data), 9);

        // Scanning keeps running during a sweep.
        mode = 1'b1; clear_req = 1'b1;
        cyc();
        clear_req = 1'b0;
        repeat (40) cyc();
        mode = 1'b0;
        repeat (2) cyc();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_ram_scanner

// File: doc/ram_scanner.md
RAM_SCANNER -- requirements
Module: ram_scanner

Interface
REQ-001 SHALL have parameter DATA_W, 4, data word width in bits (>=1).
REQ-002 SHALL have parameter ADDR_W, 5, address width; DEPTH = 2**ADDR_W words.
REQ-003 SHALL have parameter SCAN_DIV, 50_000_000, clock cycles per scan step (>=1).
REQ-004 SHALL have port clock  input  1  sole clock; all state updates on rising edge.
REQ-005 SHALL have port reset  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port wr_en  input  1  write request this cycle.
REQ-007 SHALL have port wr_addr  input  ADDR_W  write address.
REQ-008 SHALL have port wr_data  input  DATA_W  write data.
REQ-009 SHALL have port mode  input  1  0 = manual read, 1 = auto-scan read.
REQ-010 SHALL have port man_addr  input  ADDR_W  read address in manual mode.
REQ-011 SHALL have port clear_req  input  1  start a full-memory clear sweep.
REQ-012 SHALL have port rd_addr  output  ADDR_W  registered address of the displayed word.
REQ-013 SHALL have port rd_data  output  DATA_W  registered data at rd_addr.
REQ-014 SHALL have port busy  output  1  high while the clear sweep runs.
REQ-015 SHALL have port wr_drop  output  1  one-cycle pulse when a write is rejected.

Function
REQ-016 SHALL hold DEPTH x DATA_W storage with one synchronous write port and one synchronous read port.
REQ-017 SHALL select sel_addr = mode ? scan_addr : man_addr.
REQ-018 SHALL register rd_addr <= sel_addr and rd_data <= mem[sel_addr] on every edge: 1-cycle latency, rd_addr and rd_data always aligned.
REQ-019 SHALL write mem[wr_addr] <= wr_data on an edge with wr_en=1 and state IDLE.
REQ-020 SHALL, when a write (user or clear) targets sel_addr in the same cycle, load rd_data with the written value (write-first bypass).
REQ-021 SHALL run a divider counting 0..SCAN_DIV-1 while mode=1, producing a one-cycle tick at SCAN_DIV-1 and wrapping to 0.
REQ-022 SHALL hold the divider at 0 and scan_addr unchanged while mode=0; first step occurs SCAN_DIV cycles after mode rises.
REQ-023 SHALL increment scan_addr modulo DEPTH on each tick (DEPTH-1 wraps to 0); SCAN_DIV=1 steps every cycle.
REQ-024 SHALL implement states IDLE and CLEAR; IDLE -> CLEAR on clear_req=1; clear_req in CLEAR ignored.
REQ-025 SHALL, in CLEAR, write 0 to address clr_cnt each cycle, clr_cnt from 0 to DEPTH-1, then return to IDLE: exactly DEPTH cycles.
REQ-026 SHALL drive busy=1 exactly while in CLEAR (registered), low the cycle after the final clear write.
REQ-027 SHALL ignore wr_en=1 while in CLEAR and pulse wr_drop=1 for that cycle (registered, next edge).
REQ-028 SHALL keep reads and scanning running during CLEAR.

Reset
REQ-029 SHALL on reset force state IDLE, busy 0, wr_drop 0, scan_addr 0, divider 0, clr_cnt 0, rd_addr 0, rd_data 0, immediately without a clock edge.
REQ-030 SHALL NOT reset memory contents; reset mid-CLEAR aborts the sweep, leaving unvisited words intact.

Structure
REQ-031 SHALL place the state enum (IDLE, CLEAR) in shared package ram_scan_pkg.
REQ-032 SHALL implement the divider as sub-module tick_gen (parameter SCAN_DIV; ports clock, reset, en, tick).
REQ-033 SHALL infer memory with no reset so it maps to block RAM.

Verification (ADDR_W=5, DATA_W=4, SCAN_DIV=4 unless noted)
REQ-034 SHALL cover: write 8 to addr 2, then mode=0 man_addr=2 -> next cycle rd_addr=2, rd_data=8.
REQ-035 SHALL cover: wr_en, wr_addr=5, wr_data=0xA with man_addr=5 same cycle -> next cycle rd_data=0xA.
REQ-036 SHALL cover: preload mem[k]=k mod 16, mode=1 -> rd_addr steps every 4 cycles 0,1,...,31,0; rd_data tracks.
REQ-037 SHALL cover: clear_req pulse -> busy high 32 cycles; wr_en during clear -> wr_drop pulse, no write; afterwards all 32 words read 0.
REQ-038 SHALL cover: reset asserted at clear cycle 10 -> busy, rd_data drop to 0 asynchronously; mem[20] keeps its prior value.
REQ-039 SHALL cover: SCAN_DIV=1 -> rd_addr increments every cycle, 31 wraps to 0.
